// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at its centre and
// delivers bytes through a single-entry valid/ready output register.
module uart_rx #(
    parameter int unsigned CLK_FREQ_HZ = 0,
    parameter int unsigned BAUD_RATE   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    output logic [7:0] byte_out_data,
    output logic       byte_out_valid,
    input  logic       byte_out_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int unsigned TicksPerBit = (BAUD_RATE == 0) ? 0 : CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CntW        = $clog2(TicksPerBit) + 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(TicksPerBit / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(TicksPerBit - 1);

    if (TicksPerBit < 4) begin : gen_bad_cfg
        $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 4");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic            rx_prev_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;

    logic start_edge;
    logic bit_done;
    logic commit;
    logic stop_bad;

    assign start_edge = rx_prev_q & ~rx_s_q;
    assign bit_done   = (cnt_q == BitLast);

    always_comb begin
        commit   = 1'b0;
        stop_bad = 1'b0;
        if (state_q == StStop && bit_done) begin
            commit   = rx_s_q;
            stop_bad = ~rx_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            rx_meta_q      <= 1'b1;
            rx_s_q         <= 1'b1;
            rx_prev_q      <= 1'b1;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            byte_out_data  <= 8'h00;
            byte_out_valid <= 1'b0;
            frame_error    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            rx_meta_q   <= bit_in;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            frame_error <= stop_bad;
            overrun     <= 1'b0;

            // A byte may load in the same cycle the old one is taken.
            if (commit) begin
                if (!byte_out_valid || byte_out_ready) begin
                    byte_out_data  <= shift_q;
                    byte_out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (byte_out_valid && byte_out_ready) begin
                byte_out_valid <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (start_edge) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (bit_done) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames with literal expectations plus random traffic,
// all checked every cycle against a sample-point model of the receiver.
module tb_uart_rx;

    localparam int T = 16;
    localparam int H = T / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b1;
    logic       byte_out_ready = 1'b0;
    logic [7:0] byte_out_data;
    logic       byte_out_valid;
    logic       frame_error;
    logic       overrun;

    uart_rx #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD_RATE  (62_500)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_in        (bit_in),
        .byte_out_data (byte_out_data),
        .byte_out_valid(byte_out_valid),
        .byte_out_ready(byte_out_ready),
        .frame_error   (frame_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: frames are judged purely by where the sample points fall after the
    // detected start edge; h0..h2 are the line as seen through the input flops.
    bit       h0 = 1'b1, h1 = 1'b1, h2 = 1'b1;
    bit       m_busy = 1'b0;
    int       m_t = 0;
    int       m_e = 0;
    bit [7:0] m_bits = 8'h00;
    bit       m_valid = 1'b0;
    bit [7:0] m_data = 8'h00;
    bit       m_fe = 1'b0;
    bit       m_ov = 1'b0;
    bit       m_live = 1'b0;

    always @(posedge clk) begin
        bit s, p, do_commit, do_fe;
        int off, k;
        m_t++;
        s = h1;
        p = h2;
        do_commit = 1'b0;
        do_fe = 1'b0;
        if (rst) begin
            h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
            m_busy = 1'b0; m_valid = 1'b0; m_data = 8'h00; m_fe = 1'b0; m_ov = 1'b0;
        end else begin
            if (!m_busy) begin
                if (p && !s) begin
                    m_busy = 1'b1;
                    m_e = m_t;
                end
            end else begin
                off = m_t - m_e;
                if (off == H) begin
                    if (s) m_busy = 1'b0;
                end else if (off > H && (off - H) % T == 0) begin
                    k = (off - H) / T;
                    if (k <= 8) begin
                        m_bits[k-1] = s;
                    end else begin
                        m_busy = 1'b0;
                        if (s) do_commit = 1'b1;
                        else do_fe = 1'b1;
                    end
                end
            end
            m_fe = do_fe;
            m_ov = 1'b0;
            if (do_commit) begin
                if (!m_valid || byte_out_ready) begin
                    m_data = m_bits;
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (m_valid && byte_out_ready) begin
                m_valid = 1'b0;
            end
            h2 = h1; h1 = h0; h0 = bit_in;
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("valid", byte_out_valid, m_valid);
            check("data", byte_out_data, m_data);
            check("frame_error", frame_error, m_fe);
            check("overrun", overrun, m_ov);
        end
    end

    // Drive the line for n cycles; called and returns 1 time unit after a rising edge.
    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            bit_in = v;
            if (rand_ready) byte_out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop);
        hold(1'b0, T);
        for (int i = 0; i < 8; i++) hold(b[i], T);
        hold(stop, T);
    endtask

    task automatic wait_valid(input int max, output int at, output logic [7:0] d);
        at = -1;
        d = 8'hxx;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (byte_out_valid) begin
                at = cyc;
                d = byte_out_data;
                break;
            end
        end
    endtask

    initial begin
        int         p0, at, fe_cnt, v_cnt, ov_cnt;
        logic [7:0] d;
        logic       v_next;
        logic [7:0] got [3];
        logic [7:0] exp3 [3];
        exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h5A;

        repeat (4) @(posedge clk);
        #1;
        check("rst_valid", byte_out_valid, 1'b0);
        check("rst_data", byte_out_data, 8'h00);
        check("rst_fe", frame_error, 1'b0);
        check("rst_ov", overrun, 1'b0);
        rst = 1'b0;
        hold(1'b1, 20);

        // Single frame: valid appears 155 cycles after the start bit is driven, for 1 cycle.
        byte_out_ready = 1'b1;
        p0 = cyc;
        fork
            send(8'hA5, 1'b1);
            begin
                wait_valid(400, at, d);
                @(negedge clk);
                v_next = byte_out_valid;
            end
        join
        check("a5_latency", at - p0, 155);
        check("a5_data", d, 8'hA5);
        check("a5_one_cycle", v_next, 1'b0);
        hold(1'b1, T);

        fork
            begin send(8'h00, 1'b1); send(8'hFF, 1'b1); send(8'h5A, 1'b1); end
            for (int j = 0; j < 3; j++) begin
                wait_valid(400, at, d);
                got[j] = d;
            end
        join
        for (int j = 0; j < 3; j++) check("b2b_data", got[j], exp3[j]);
        hold(1'b1, T);

        // Bad stop bit, then a long break: one frame_error and nothing else.
        fe_cnt = 0;
        v_cnt = 0;
        fork
            begin send(8'h55, 1'b0); hold(1'b0, 40 * T); hold(1'b1, 2 * T); end
            for (int i = 0; i < 52 * T - 2; i++) begin
                @(negedge clk);
                fe_cnt += int'(frame_error);
                v_cnt += int'(byte_out_valid);
            end
        join
        check("fe_count", fe_cnt, 1);
        check("fe_no_valid", v_cnt, 0);
        fork
            send(8'h3C, 1'b1);
            wait_valid(400, at, d);
        join
        check("after_break_data", d, 8'h3C);
        hold(1'b1, T);

        // Stalled consumer: second byte overruns and is dropped.
        byte_out_ready = 1'b0;
        ov_cnt = 0;
        fork
            begin send(8'h11, 1'b1); send(8'h22, 1'b1); end
            for (int i = 0; i < 20 * T - 2; i++) begin
                @(negedge clk);
                ov_cnt += int'(overrun);
            end
        join
        check("ov_count", ov_cnt, 1);
        check("ov_held_valid", byte_out_valid, 1'b1);
        check("ov_held_data", byte_out_data, 8'h11);
        byte_out_ready = 1'b1;
        @(posedge clk);
        #1;
        byte_out_ready = 1'b0;
        check("drain_valid", byte_out_valid, 1'b0);
        hold(1'b1, T);

        // Ready only on the commit edge of the second byte: swap without overrun.
        send(8'h11, 1'b1);
        fork
            send(8'h22, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                byte_out_ready = 1'b1;
                @(posedge clk);
                #1;
                byte_out_ready = 1'b0;
                check("swap_valid", byte_out_valid, 1'b1);
                check("swap_data", byte_out_data, 8'h22);
                check("swap_ov", overrun, 1'b0);
            end
        join
        hold(1'b1, T);

        hold(1'b0, 4);
        hold(1'b1, 3 * T);
        check("glitch_data", byte_out_data, 8'h22);

        // Reset during data bit 3 of 8'h0F while the line is high.
        hold(1'b0, T);
        for (int i = 0; i < 3; i++) hold(1'b1, T);
        hold(1'b1, H);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_valid", byte_out_valid, 1'b0);
        check("midrst_data", byte_out_data, 8'h00);
        check("midrst_fe", frame_error, 1'b0);
        check("midrst_ov", overrun, 1'b0);
        hold(1'b1, 10 * T);
        byte_out_ready = 1'b1;
        fork
            send(8'h81, 1'b1);
            wait_valid(400, at, d);
        join
        check("post_rst_data", d, 8'h81);
        hold(1'b1, T);

        // Random traffic: gaps (often none), bad stops, glitches and random ready.
        rand_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                hold(1'b0, $urandom_range(1, 6));
                hold(1'b1, T);
            end
            send(8'($urandom), $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) != 0) hold(1'b1, $urandom_range(1, 2 * T));
        end
        rand_ready = 1'b0;
        byte_out_ready = 1'b1;
        hold(1'b1, 12 * T);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
